ecc_seq: RTL and testbench
==========================

# ecc_seq

Microcode sequencer for the ECC coprocessor. Drives the 8-bit address of the combinational microcode ROM, decodes each returned 20-bit instruction, runs a single-level hardware loop, and dispatches datapath operations over a valid/ready handshake. Sits between the host start/done control and the field-arithmetic datapath; the ROM is its only instruction source.

## Interface
- `PROG_LEN`, 77: number of program words. The program ends when the next PC equals `PROG_LEN`; range 1..256.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to run the program from address 0. Ignored unless `busy` = 0.
- `ins_addr`  out  8  ROM address; equals the PC register.
- `ins_read`  in  20  ROM data, combinational from `ins_addr`. Fields: `[19:17]` opcode, `[16]` flag, `[15:8]` field A, `[7:0]` field B.
- `op_valid`  out  1  datapath operation pending.
- `op_ready`  in  1  datapath accepts the operation.
- `op_code`  out  3  registered opcode.
- `op_flag`  out  1  registered flag.
- `op_a`  out  8  registered field A.
- `op_b`  out  8  registered field B.
- `busy`  out  1  high from the cycle after an accepted start through the done cycle.
- `done`  out  1  one-cycle pulse when the program completes.
- `loop_err`  out  1  sticky; set when a LOOP arrives while a loop is already active. Cleared only by reset or an accepted `start`.

## Operation
States:
- **IDLE**
  - PC = 0, `busy` = 0.
  - `start` → RUN. Clears `loop_err` and loop state.
- **RUN**: decode `ins_read` at PC.
  - `000` NOP: advance.
  - `010` LOOP: see Configuration.
  - Any other opcode (`001`, `011`–`111`): latch all four fields into the `op_*` registers, set `op_valid` = 1, go to ISSUE. PC holds.
- **ISSUE**
  - Hold `op_valid` and `op_*` stable until `op_ready` = 1.
  - In that cycle, clear `op_valid`, advance, and return to RUN.
- **DONE**: `done` = 1 for exactly one cycle, then IDLE. PC resets to 0 and `busy` = 0 in IDLE.

Advance rule, applied in priority order:
1. Loop active, PC == `lp_end`, and `lp_cnt` ≠ 0: PC ← `lp_start`, `lp_cnt` ← `lp_cnt` − 1.
2. Loop active, PC == `lp_end`, and `lp_cnt` == 0: loop becomes inactive, next = PC + 1.
3. Otherwise: next = PC + 1.
4. If next == `PROG_LEN`: go to DONE.

Other rules:
- PC arithmetic is 9-bit internally, so `PROG_LEN` = 256 terminates without wrapping.
- A loop end past the program end is clipped: termination wins.
- Reset mid-run: all registers return to reset values immediately. Any pending `op_valid` drops with no handshake.
- Reset values:
  - `ins_addr` = 0, `op_valid` = 0, `op_code` / `op_flag` / `op_a` / `op_b` = 0.
  - `busy` = 0, `done` = 0, `loop_err` = 0.
  - Loop registers = 0, loop inactive, state IDLE.

## Timing
- ROM lookup is zero-latency; decode occurs in the same cycle PC is presented.
- Per-instruction cost:
  - NOP and LOOP: 1 cycle.
  - Dispatched op: 1 RUN cycle, plus 1 or more ISSUE cycles, ending in the `op_ready` cycle. Minimum 2 cycles.
- `start` accepted in cycle T → RUN at T+1, `busy` = 1 at T+1.
- `done` is asserted the cycle after the final advance. `busy` stays 1 during that cycle and drops the next cycle.
- `start` during `busy` = 1, including the done cycle, is ignored.

## Configuration
- `ECC_SEQ_LOOP_EN` defined: LOOP with A ≠ 0 and B ≠ 0
  - loads `lp_start` = PC + 1, `lp_end` = PC + B, `lp_cnt` = A − 1, and sets the loop active;
  - then advances.
  - The body therefore executes A times in total.
  - LOOP with A = 0 or B = 0 behaves as NOP.
  - LOOP while already active: sets `loop_err`, otherwise behaves as NOP, and the current loop continues.
- Not defined:
  - LOOP always behaves as NOP.
  - Loop registers and the comparator are not built.
  - `loop_err` is tied to 0.

## Test plan
- All-NOP ROM, `PROG_LEN` = 4, `start` pulse → `ins_addr` 0,1,2,3 on consecutive cycles; `done` pulses at cycle 5 after start; `busy` high 5 cycles.
- ROM word 1 = `111_1_00000100_00000111`, `op_ready` held low 3 cycles → `op_valid` = 1 with `op_code` 7, `op_flag` 1, `op_a` 4, `op_b` 7, stable throughout; PC stays at 1 until ready, then 2.
- Loop enabled; word 0 = LOOP A=3 B=2, words 1–2 = op `011`, `op_ready` tied 1 → exactly 6 dispatches, address sequence 1,2,1,2,1,2, then 3.
- Nested LOOP inside an active body (macro on) → `loop_err` = 1 and stays 1; outer loop count unchanged. The same program with the macro off → `loop_err` = 0, single pass through the body.
- `rst` asserted while in ISSUE → `op_valid`, `busy`, `ins_addr` = 0 asynchronously. A following `start` runs from address 0.
- `start` pulsed mid-run and in the done cycle → ignored; exactly one `done` per accepted start.

Source files
------------

// File: rtl/ecc_seq_if.sv
// Sequencer bus: host start/done control, microcode ROM port and datapath dispatch handshake.
// master = sequencer side, slave = host/ROM/datapath side.
interface ecc_seq_if;
  logic        start;
  logic [7:0]  ins_addr;
  logic [19:0] ins_read;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic        op_flag;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        busy;
  logic        done;
  logic        loop_err;

  modport master (
    input  start, ins_read, op_ready,
    output ins_addr, op_valid, op_code, op_flag, op_a, op_b, busy, done, loop_err
  );

  modport slave (
    output start, ins_read, op_ready,
    input  ins_addr, op_valid, op_code, op_flag, op_a, op_b, busy, done, loop_err
  );
endinterface

// File: rtl/ecc_seq.sv
// ECC coprocessor microcode sequencer: walks the microcode ROM, dispatches datapath ops over
// valid/ready and optionally runs a single-level hardware loop.
// Optional feature: define ECC_SEQ_LOOP_EN to build the hardware loop and loop_err tracking;
// without it LOOP decodes as NOP and loop_err is tied low.
module ecc_seq #(
  parameter int unsigned PROG_LEN = 77
) (
  input logic        clk,
  input logic        rst,
  ecc_seq_if.master  bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StIssue, StDone} state_e;

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpLoop = 3'b010;
  // 9-bit so a 256-word program terminates instead of wrapping
  localparam logic [8:0] ProgEnd = 9'(PROG_LEN);

  state_e      state_q, state_d;
  logic [8:0]  pc_q, pc_d;
  logic        op_valid_q, op_valid_d;
  logic [2:0]  op_code_q, op_code_d;
  logic        op_flag_q, op_flag_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;

  logic [2:0]  opcode;
  logic        flag;
  logic [7:0]  fld_a, fld_b;
  logic [8:0]  adv_pc;
  logic        adv_req;

  assign opcode = bus_io.ins_read[19:17];
  assign flag   = bus_io.ins_read[16];
  assign fld_a  = bus_io.ins_read[15:8];
  assign fld_b  = bus_io.ins_read[7:0];

`ifdef ECC_SEQ_LOOP_EN
  logic        lp_active_q, lp_active_d;
  logic [8:0]  lp_start_q, lp_start_d;
  logic [8:0]  lp_end_q, lp_end_d;
  logic [7:0]  lp_cnt_q, lp_cnt_d;
  logic        loop_err_q, loop_err_d;
  logic        loop_hit;
  logic        loop_dec;

  assign loop_hit = lp_active_q && (pc_q == lp_end_q);
  assign loop_dec = (state_q == StRun) && (opcode == OpLoop);
  // Loop load uses the pre-load state: a fresh loop can never hit its end on the LOOP word itself
  assign adv_pc   = (loop_hit && (lp_cnt_q != 8'd0)) ? lp_start_q : pc_q + 9'd1;

  // Loop bookkeeping: clear on accepted start, load/flag on LOOP, count down at body end
  always_comb begin
    lp_active_d = lp_active_q;
    lp_start_d  = lp_start_q;
    lp_end_d    = lp_end_q;
    lp_cnt_d    = lp_cnt_q;
    loop_err_d  = loop_err_q;
    if ((state_q == StIdle) && bus_io.start) begin
      lp_active_d = 1'b0;
      lp_start_d  = '0;
      lp_end_d    = '0;
      lp_cnt_d    = '0;
      loop_err_d  = 1'b0;
    end else begin
      if (loop_dec) begin
        if (lp_active_q) begin
          loop_err_d = 1'b1;
        end else if ((fld_a != 8'd0) && (fld_b != 8'd0)) begin
          lp_active_d = 1'b1;
          lp_start_d  = pc_q + 9'd1;
          lp_end_d    = pc_q + {1'b0, fld_b};
          lp_cnt_d    = fld_a - 8'd1;
        end
      end
      if (adv_req && loop_hit) begin
        if (lp_cnt_q != 8'd0) lp_cnt_d = lp_cnt_q - 8'd1;
        else                  lp_active_d = 1'b0;
      end
    end
  end

  // Loop state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_active_q <= 1'b0;
      lp_start_q  <= '0;
      lp_end_q    <= '0;
      lp_cnt_q    <= '0;
      loop_err_q  <= 1'b0;
    end else begin
      lp_active_q <= lp_active_d;
      lp_start_q  <= lp_start_d;
      lp_end_q    <= lp_end_d;
      lp_cnt_q    <= lp_cnt_d;
      loop_err_q  <= loop_err_d;
    end
  end

  assign bus_io.loop_err = loop_err_q;
`else
  assign adv_pc          = pc_q + 9'd1;
  assign bus_io.loop_err = 1'b0;
`endif

  // Sequencer next state: decode, dispatch handshake, PC advance and termination
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_valid_d = op_valid_q;
    op_code_d  = op_code_q;
    op_flag_d  = op_flag_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    adv_req    = 1'b0;
    unique case (state_q)
      StIdle: begin
        pc_d = '0;
        if (bus_io.start) state_d = StRun;
      end
      StRun: begin
        if ((opcode == OpNop) || (opcode == OpLoop)) begin
          adv_req = 1'b1;
        end else begin
          op_code_d  = opcode;
          op_flag_d  = flag;
          op_a_d     = fld_a;
          op_b_d     = fld_b;
          op_valid_d = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (bus_io.op_ready) begin
          op_valid_d = 1'b0;
          adv_req    = 1'b1;
          state_d    = StRun;
        end
      end
      StDone: begin
        state_d = StIdle;
        pc_d    = '0;
      end
      default: state_d = StIdle;
    endcase
    // Termination beats any loop-back target past the program end
    if (adv_req) begin
      if (adv_pc == ProgEnd) begin
        state_d = StDone;
        pc_d    = '0;
      end else begin
        pc_d = adv_pc;
      end
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      op_valid_q <= 1'b0;
      op_code_q  <= '0;
      op_flag_q  <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_valid_q <= op_valid_d;
      op_code_q  <= op_code_d;
      op_flag_q  <= op_flag_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
    end
  end

  assign bus_io.ins_addr = pc_q[7:0];
  assign bus_io.op_valid = op_valid_q;
  assign bus_io.op_code  = op_code_q;
  assign bus_io.op_flag  = op_flag_q;
  assign bus_io.op_a     = op_a_q;
  assign bus_io.op_b     = op_b_q;
  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.done     = (state_q == StDone);

endmodule

// File: tb/tb_ecc_seq.sv
// Bench for ecc_seq: a ROM image is interpreted into an expected instruction trace, then the
// DUT is run against it cycle by cycle with random op_ready and stray start pulses.
module tb_ecc_seq;

  localparam int unsigned ProgLen = 16;
`ifdef ECC_SEQ_LOOP_EN
  localparam bit LoopEn = 1'b1;
`else
  localparam bit LoopEn = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [19:0] rom [0:255];

  ecc_seq_if bus ();

  ecc_seq #(.PROG_LEN(ProgLen)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  assign bus.ins_read = rom[bus.ins_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected trace: PC of every executed instruction and loop_err as seen while it executes
  int tr_pc[$];
  bit tr_err[$];
  bit fin_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic build_trace();
    int pc, ls, le, cnt, nxt, op, a, b;
    bit act, err;
    logic [19:0] w;
    pc = 0; ls = 0; le = 0; cnt = 0; act = 0; err = 0;
    tr_pc.delete();
    tr_err.delete();
    forever begin
      w  = rom[pc];
      op = int'(w[19:17]);
      a  = int'(w[15:8]);
      b  = int'(w[7:0]);
      tr_pc.push_back(pc);
      tr_err.push_back(err);
      if (LoopEn && op == 2) begin
        if (act) err = 1'b1;
        else if (a != 0 && b != 0) begin
          ls = pc + 1; le = pc + b; cnt = a - 1; act = 1'b1;
        end
      end
      if (act && pc == le) begin
        if (cnt != 0) begin nxt = ls; cnt--; end
        else begin act = 1'b0; nxt = pc + 1; end
      end else begin
        nxt = pc + 1;
      end
      if (nxt == int'(ProgLen)) break;
      pc = nxt;
    end
    fin_err = err;
  endtask

  task automatic gen_rom();
    for (int i = 0; i < 256; i++) begin
      int r;
      logic [2:0] op;
      logic [7:0] a, b;
      r = $urandom_range(0, 7);
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (r <= 2) op = 3'd0;
      else if (r <= 4) begin
        op = 3'd2;
        a  = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 7) != 0) b = 8'($urandom_range(0, 5));
      end else begin
        op = 3'($urandom_range(3, 7));
        if (op == 3'd3 && $urandom_range(0, 1) == 1) op = 3'd1;
      end
      rom[i] = {op, 1'($urandom_range(0, 1)), a, b};
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 20'h0;
  endtask

  // One start-to-idle run of the current ROM, checked against the interpreted trace
  task automatic run_prog(input int unsigned rdy_pct, input bit noisy_start);
    int k, cyc;
    bit issuing, rdy, disp;
    logic [19:0] w;
    build_trace();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; cyc = 0; issuing = 1'b0;
    while (k < tr_pc.size()) begin
      if (cyc > 5000) begin
        check_eq("timeout", cyc, 0);
        break;
      end
      w = rom[tr_pc[k]];
      check_eq("busy", bus.busy, 1);
      check_eq("ins_addr", bus.ins_addr, tr_pc[k]);
      check_eq("done_early", bus.done, 0);
      check_eq("loop_err", bus.loop_err, tr_err[k]);
      disp = !(w[19:17] == 3'd0 || w[19:17] == 3'd2);
      rdy  = ($urandom_range(0, 99) < rdy_pct);
      bus.op_ready = rdy;
      bus.start    = noisy_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!disp) begin
        check_eq("valid_nop", bus.op_valid, 0);
        k++;
      end else if (!issuing) begin
        check_eq("valid_run", bus.op_valid, 0);
        issuing = 1'b1;
      end else begin
        check_eq("valid_issue", bus.op_valid, 1);
        check_eq("op_code", bus.op_code, w[19:17]);
        check_eq("op_flag", bus.op_flag, w[16]);
        check_eq("op_a", bus.op_a, w[15:8]);
        check_eq("op_b", bus.op_b, w[7:0]);
        if (rdy) begin
          issuing = 1'b0;
          k++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    // Done cycle; a start here must be ignored
    check_eq("done_pulse", bus.done, 1);
    check_eq("busy_done", bus.busy, 1);
    check_eq("valid_done", bus.op_valid, 0);
    check_eq("loop_err_end", bus.loop_err, fin_err);
    bus.start    = 1'b1;
    bus.op_ready = 1'b0;
    @(negedge clk);
    check_eq("done_clear", bus.done, 0);
    check_eq("busy_idle", bus.busy, 0);
    check_eq("addr_idle", bus.ins_addr, 0);
    check_eq("loop_err_sticky", bus.loop_err, fin_err);
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("start_in_done_ignored", bus.busy, 0);
  endtask

  task automatic reset_in_issue();
    clear_rom();
    rom[2] = {3'd5, 1'b1, 8'hAA, 8'h55};
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_valid", bus.op_valid, 1);
    check_eq("pre_rst_addr", bus.ins_addr, 2);
    #1 rst = 1'b1;
    #1;
    check_eq("rst_valid", bus.op_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_addr", bus.ins_addr, 0);
    check_eq("rst_code", bus.op_code, 0);
    check_eq("rst_a", bus.op_a, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.op_ready = 1'b0;
    clear_rom();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("reset_addr", bus.ins_addr, 0);
    check_eq("reset_valid", bus.op_valid, 0);
    check_eq("reset_code", bus.op_code, 0);
    check_eq("reset_flag", bus.op_flag, 0);
    check_eq("reset_a", bus.op_a, 0);
    check_eq("reset_b", bus.op_b, 0);
    check_eq("reset_busy", bus.busy, 0);
    check_eq("reset_done", bus.done, 0);
    check_eq("reset_loop_err", bus.loop_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All NOP: straight walk of the program
    run_prog(50, 1'b0);

    // Single dispatch with full field pattern and slow ready
    clear_rom();
    rom[1] = 20'hF0407;
    run_prog(30, 1'b1);

    // LOOP A=3 B=2 over two dispatches, ready always high
    clear_rom();
    rom[0] = {3'd2, 1'b0, 8'd3, 8'd2};
    rom[1] = {3'd3, 1'b0, 8'h11, 8'h22};
    rom[2] = {3'd3, 1'b1, 8'h33, 8'h44};
    run_prog(100, 1'b0);

    // Nested LOOP inside an active body
    clear_rom();
    rom[0] = {3'd2, 1'b0, 8'd2, 8'd3};
    rom[1] = {3'd4, 1'b0, 8'h01, 8'h02};
    rom[2] = {3'd2, 1'b0, 8'd2, 8'd1};
    rom[3] = {3'd6, 1'b1, 8'h03, 8'h04};
    run_prog(70, 1'b1);

    // LOOP running past the program end
    clear_rom();
    rom[13] = {3'd2, 1'b0, 8'd3, 8'd9};
    rom[14] = {3'd1, 1'b0, 8'h05, 8'h06};
    run_prog(60, 1'b0);

    for (int n = 0; n < 25; n++) begin
      gen_rom();
      run_prog(30 + $urandom_range(0, 70), 1'($urandom_range(0, 1)));
    end

    reset_in_issue();
    gen_rom();
    run_prog(50, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
